// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word/byte loads and stores behind a request/ready
// handshake, with WAIT_STATES extra cycles per access and a misaligned-word fault flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic        MemByte,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MemFault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    // Handshake: a request is accepted on the rising edge where the FSM is IDLE and
    // MemReq=1; MemBusy covers WAIT and DONE, MemReady/MemFault pulse for the DONE cycle.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_write;
    logic          lat_byte;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req_write;
    logic          req_byte;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_word;
    logic          req_fault;
    logic [31:0]   load_data;
    logic          enter_done;
    logic          lat_fault;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^Addr[31:AW+2];

    // With zero wait states DONE is entered straight from IDLE, before the latches are valid.
    always_comb begin
        req_write  = lat_write;
        req_byte   = lat_byte;
        req_addr   = lat_addr;
        if (state == S_IDLE) begin
            req_write = MemWrite;
            req_byte  = MemByte;
            req_addr  = Addr[AW+1:0];
        end
        req_word  = mem[req_addr[AW+1:2]];
        req_fault = !req_byte && (req_addr[1:0] != 2'b00);
        load_data = '0;
        if (req_byte)
            load_data = {24'b0, req_word[{req_addr[1:0], 3'b000} +: 8]};
        else if (!req_fault)
            load_data = req_word;
        enter_done = ((state == S_IDLE) && MemReq && (WS == 4'd0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ReadData  <= '0;
            MemReady  <= 1'b0;
            MemBusy   <= 1'b0;
            MemFault  <= 1'b0;
        end else begin
            MemReady <= 1'b0;
            MemFault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MemReq) begin
                        lat_write <= MemWrite;
                        lat_byte  <= MemByte;
                        lat_addr  <= Addr[AW+1:0];
                        lat_wdata <= WriteData;
                        cnt       <= WS;
                        MemBusy   <= 1'b1;
                        state     <= (WS == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_DONE;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    MemBusy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
            if (enter_done) begin
                MemReady <= 1'b1;
                MemFault <= req_fault;
                if (!req_write)
                    ReadData <= load_data;
            end
        end
    end

    assign lat_fault = !lat_byte && (lat_addr[1:0] != 2'b00);

    // Stores commit on the edge that leaves DONE; a reset mid-access never reaches it.
    always_ff @(posedge clk) begin
        if (state == S_DONE && lat_write && !lat_fault) begin
            if (lat_byte)
                mem[lat_addr[AW+1:2]][{lat_addr[1:0], 3'b000} +: 8] <= lat_wdata[7:0];
            else
                mem[lat_addr[AW+1:2]] <= lat_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table vectors, random accesses against a word-array model,
// reset-abort and zero-wait-state throughput sequences.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr, byt;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, busy, fault;
    logic        req0;
    logic [31:0] rdata0;
    logic        ready0, busy0, fault0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .MemReq(req), .MemWrite(wr), .MemByte(byt),
        .Addr(addr), .WriteData(wdata), .ReadData(rdata), .MemReady(ready),
        .MemBusy(busy), .MemFault(fault)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(wr), .MemByte(byt),
        .Addr(addr), .WriteData(wdata), .ReadData(rdata0), .MemReady(ready0),
        .MemBusy(busy0), .MemFault(fault0)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] rd_model;

    typedef struct packed {
        logic        wr;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;
    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Little-endian byte-addressed memory seen as an array of words.
    function automatic logic [31:0] model(input logic w, input logic b,
                                          input logic [31:0] a, input logic [31:0] d,
                                          output logic f);
        int idx;
        int lane;
        idx  = int'((a >> 2) % DEPTH);
        lane = int'(a % 4);
        f = 1'b0;
        if (!b && lane != 0) begin
            f = 1'b1;
            if (!w) rd_model = 32'h0;
        end else if (b) begin
            if (w)
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
            else
                rd_model = (ref_mem[idx] >> (8 * lane)) & 32'hFF;
        end else begin
            if (w) ref_mem[idx] = d;
            else   rd_model = ref_mem[idx];
        end
        return rd_model;
    endfunction

    task automatic access(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got_rd, output logic got_f);
        logic [31:0] exp_rd;
        logic        exp_f;
        int          busy_n;
        int          lat;
        bit          seen;
        exp_rd = model(w, b, a, d, exp_f);
        @(negedge clk);
        req = 1'b1; wr = w; byt = b; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 1'b0; busy_n = 0; lat = 0; got_rd = '0; got_f = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (busy) busy_n++;
            if (ready) begin
                seen = 1'b1; lat = k; got_rd = rdata; got_f = fault;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        check("latency", 32'(lat), 32'(WS + 1));
        check("busy_cycles", 32'(busy_n), 32'(WS + 1));
        check("fault", 32'(got_f), 32'(exp_f));
        check("rdata", got_rd, exp_rd);
        @(posedge clk); #1;
        check("busy_after", 32'(busy), 32'd0);
        check("ready_pulse", 32'(ready), 32'd0);
        check("rdata_hold", rdata, exp_rd);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] rd;
        logic        f;
        logic        w, b;
        logic [31:0] a, d;

        vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h11,  32'hFFFFFFA5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h1122A544, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h13,  32'h0,        32'h00000011, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h11,  32'h0,        32'h000000A5, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h20,  32'h01020304, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h22,  32'hCAFEF00D, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h01020304, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h22,  32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h102, 32'h0,        32'h00000034, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h30,  32'h00000000, 32'h0,        1'b0};

        reset = 1'b0; req = 1'b0; req0 = 1'b0; wr = 1'b0; byt = 1'b0;
        addr = '0; wdata = '0; rd_model = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 1'b0, 32'(i * 4), $urandom, rd, f);

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].wr, vecs[i].byt, vecs[i].addr, vecs[i].wdata, rd, f);
            check("vec_fault", 32'(f), 32'(vecs[i].exp_flt));
            if (!vecs[i].wr) check("vec_rdata", rd, vecs[i].exp_rd);
        end

        repeat (150) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 511));
            d = $urandom;
            access(w, b, a, d, rd, f);
        end

        // Reset during WAIT of a store must leave the RAM untouched.
        access(1'b1, 1'b0, 32'h30, 32'h0, rd, f);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; byt = 1'b0; addr = 32'h30; wdata = 32'h55555555;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_busy_wait", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        rd_model = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_ready", 32'(ready), 32'd0);
        end
        access(1'b0, 1'b0, 32'h30, 32'h0, rd, f);
        check("abort_load", rd, 32'h0);

        // Zero wait states with MemReq held: one completion every second cycle.
        @(negedge clk);
        wr = 1'b1; byt = 1'b0; addr = 32'h40; wdata = 32'hA1B2C3D4; req0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("ws0_ready_pattern", 32'(ready0), 32'((i % 2) == 0));
            check("ws0_busy_pattern", 32'(busy0), 32'((i % 2) == 0));
        end
        @(negedge clk);
        req0 = 1'b0; wr = 1'b0;
        @(negedge clk) req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        check("ws0_load_ready", 32'(ready0), 32'd1);
        check("ws0_load_rdata", rdata0, 32'hA1B2C3D4);
        check("ws0_load_fault", 32'(fault0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
